// File: rtl/mon_packet_tx_if.sv
`default_nettype none
// ============================================================================
// mon_packet_tx_if : valid/ready packet port feeding the monitor-link serializer
// Rev 1.0
// ============================================================================
interface mon_packet_tx_if;
  logic [39:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport master (output tx_data, output tx_valid, input  tx_ready);
  modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface
`default_nettype wire

// File: rtl/mon_packet_tx.sv
`default_nettype none
// ============================================================================
// mon_packet_tx : 40-bit monitor-link packet serializer behind a 2-entry FIFO
// Rev 1.0
// ============================================================================
module mon_packet_tx #(
  parameter int GAP = 4
) (
  input  logic             mon_clk,
  input  logic             rst_n,
  mon_packet_tx_if.slave   tx,
  output logic             to_mon,
  output logic             sent,
  output logic             busy
);

  localparam logic [7:0] C_GAP_LOAD = 8'(GAP - 1);
  localparam logic [5:0] C_BIT_LOAD = 6'd39;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic [5:0]  bit_cnt, bit_cnt_nxt;
  logic [7:0]  gap_cnt, gap_cnt_nxt;
  logic [39:0] shreg, shreg_nxt;
  logic        to_mon_nxt, sent_nxt, busy_nxt;

  logic [39:0] mem [2];
  logic        wr_ptr, rd_ptr;
  logic [1:0]  count;
  logic        push, pop;

  assign tx.tx_ready = (count != 2'd2);
  assign push        = tx.tx_valid && tx.tx_ready;

  always_ff @(posedge mon_clk) begin
    if (push) begin
      mem[wr_ptr] <= tx.tx_data;
    end
  end

  // Line outputs are registered from the current state, so each bit appears
  // one edge after the FSM enters the state that produces it.
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    gap_cnt_nxt = gap_cnt;
    shreg_nxt   = shreg;
    pop         = 1'b0;
    to_mon_nxt  = 1'b1;
    sent_nxt    = 1'b0;
    busy_nxt    = (state != ST_IDLE) || (count != 2'd0);
    case (state)
      ST_IDLE: begin
        if (count != 2'd0) begin
          pop       = 1'b1;
          shreg_nxt = mem[rd_ptr];
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        to_mon_nxt  = 1'b0;
        bit_cnt_nxt = C_BIT_LOAD;
        state_nxt   = ST_DATA;
      end
      ST_DATA: begin
        to_mon_nxt = shreg[39];
        shreg_nxt  = {shreg[38:0], 1'b0};
        if (bit_cnt == 6'd0) begin
          state_nxt = ST_STOP;
        end else begin
          bit_cnt_nxt = bit_cnt - 6'd1;
        end
      end
      ST_STOP: begin
        sent_nxt    = 1'b1;
        gap_cnt_nxt = C_GAP_LOAD;
        state_nxt   = ST_GAP;
      end
      ST_GAP: begin
        if (gap_cnt == 8'd0) begin
          if (count != 2'd0) begin
            pop       = 1'b1;
            shreg_nxt = mem[rd_ptr];
            state_nxt = ST_START;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else begin
          gap_cnt_nxt = gap_cnt - 8'd1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge mon_clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      gap_cnt <= '0;
      shreg   <= '0;
      to_mon  <= 1'b1;
      sent    <= 1'b0;
      busy    <= 1'b0;
      count   <= 2'd0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      gap_cnt <= gap_cnt_nxt;
      shreg   <= shreg_nxt;
      to_mon  <= to_mon_nxt;
      sent    <= sent_nxt;
      busy    <= busy_nxt;
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mon_packet_tx.sv
`default_nettype none
// ============================================================================
// tb_mon_packet_tx : directed bench with a receiver model decoding both lines
// Rev 1.0
// ============================================================================
module tb_mon_packet_tx;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mon_packet_tx_if if0 ();
  mon_packet_tx_if if1 ();
  logic to_mon0, sent0, busy0;
  logic to_mon1, sent1, busy1;

  mon_packet_tx #(.GAP(4)) dut0 (
    .mon_clk(clk), .rst_n(rst_n), .tx(if0),
    .to_mon(to_mon0), .sent(sent0), .busy(busy0)
  );
  mon_packet_tx #(.GAP(1)) dut1 (
    .mon_clk(clk), .rst_n(rst_n), .tx(if1),
    .to_mon(to_mon1), .sent(sent1), .busy(busy1)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Receiver model of the sound-box deserializer, one per link.
  logic [39:0] rx_word  [2][512];
  int          rx_start [2][512];
  int          rx_run   [2][512];
  int          rx_n     [2] = '{0, 0};
  int          sent_cnt [2] = '{0, 0};
  int          rx_st    [2] = '{0, 0};
  int          rx_bits  [2] = '{0, 0};
  int          run      [2] = '{0, 0};
  logic [39:0] rx_sh    [2];
  logic        ln       [2];
  logic        sn       [2];
  int          cyc = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    ln[0] = to_mon0; ln[1] = to_mon1;
    sn[0] = sent0;   sn[1] = sent1;
    for (int c = 0; c < 2; c++) begin
      if (!rst_n) begin
        rx_st[c] = 0;
        run[c]   = 0;
      end else begin
        if (sn[c]) sent_cnt[c]++;
        case (rx_st[c])
          0: begin
            if (ln[c]) begin
              run[c]++;
            end else begin
              rx_start[c][rx_n[c]] = cyc;
              rx_run[c][rx_n[c]]   = run[c];
              rx_bits[c] = 0;
              rx_st[c]   = 1;
            end
          end
          1: begin
            rx_sh[c] = {rx_sh[c][38:0], ln[c]};
            rx_bits[c]++;
            if (rx_bits[c] == 40) rx_st[c] = 2;
          end
          default: begin
            chk("stop_bit", 64'(ln[c]), 64'd1);
            chk("sent_at_stop", 64'(sn[c]), 64'd1);
            rx_word[c][rx_n[c]] = rx_sh[c];
            rx_n[c]++;
            run[c]   = ln[c] ? 1 : 0;
            rx_st[c] = 0;
          end
        endcase
      end
    end
  end

  logic [39:0] exp_q [$];

  task automatic wait_rx(input int ch, input int target, input int limit);
    int n = 0;
    while (rx_n[ch] < target && n < limit) begin
      @(negedge clk);
      n++;
    end
    repeat (60) @(negedge clk);
    chk("rx_frame_count", 64'(rx_n[ch]), 64'(target));
  endtask

  task automatic cmp_words(input int ch, input int base);
    for (int i = 0; i < exp_q.size(); i++) begin
      chk("rx_word", 64'(rx_word[ch][base + i]), 64'(exp_q[i]));
    end
  endtask

  task automatic wait_idle0();
    int n = 0;
    while ((busy0 || !to_mon0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", 64'(busy0), 64'd0);
  endtask

  localparam logic [39:0] C_W [4] = '{40'h01_2345_6789, 40'hFE_DCBA_9876,
                                       40'h80_0000_0001, 40'h7F_FFFF_FFFE};

  initial begin
    logic [39:0] d;
    logic        exp_bit;
    logic        r, v;
    int          acc, low_after, base, lows, nbefore, s0, g;

    if0.tx_valid = 1'b0; if0.tx_data = '0;
    if1.tx_valid = 1'b0; if1.tx_data = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_to_mon", 64'(to_mon0), 64'd1);
    chk("rst_sent", 64'(sent0), 64'd0);
    chk("rst_busy", 64'(busy0), 64'd0);
    chk("rst_ready", 64'(if0.tx_ready), 64'd1);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single frame, cycle-exact against the accept edge N.
    d    = 40'hC0_0000_00FF;
    base = rx_n[0];
    if0.tx_data = d; if0.tx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if0.tx_valid = 1'b0;
    chk("single_busy_k0", 64'(busy0), 64'd0);
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (k == 2)                 exp_bit = 1'b0;
      else if (k >= 3 && k <= 42) exp_bit = d[42 - k];
      else                        exp_bit = 1'b1;
      chk($sformatf("single_line_k%0d", k), 64'(to_mon0), 64'(exp_bit));
      chk($sformatf("single_sent_k%0d", k), 64'(sent0), 64'(k == 43));
      chk($sformatf("single_busy_k%0d", k), 64'(busy0), 64'(k < 48));
    end
    exp_q = '{d};
    wait_rx(0, base + 1, 200);
    cmp_words(0, base);

    // tx_valid held for four words.
    wait_idle0();
    base = rx_n[0]; acc = 0; low_after = -1; g = 0;
    while (acc < 4 && g < 1000) begin
      if0.tx_data = C_W[acc]; if0.tx_valid = 1'b1;
      r = if0.tx_ready;
      if (!r && low_after < 0) low_after = acc;
      @(posedge clk);
      if (r) acc++;
      @(negedge clk);
      g++;
    end
    if0.tx_valid = 1'b0;
    chk("held_accepts", 64'(acc), 64'd4);
    chk("ready_low_after", 64'(low_after), 64'd3);
    exp_q = '{C_W[0], C_W[1], C_W[2], C_W[3]};
    wait_rx(0, base + 4, 400);
    cmp_words(0, base);
    for (int i = 1; i < 4; i++) begin
      chk("b2b_period", 64'(rx_start[0][base + i] - rx_start[0][base + i - 1]), 64'd46);
      chk("b2b_high_run", 64'(rx_run[0][base + i]), 64'd5);
    end

    // GAP=1 instance, two words back to back.
    base = rx_n[1];
    if1.tx_data = 40'hA5_5A5A_A5A5; if1.tx_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    if1.tx_data = 40'h3C_C3C3_3C3C;
    @(posedge clk); @(negedge clk);
    if1.tx_valid = 1'b0;
    exp_q = '{40'hA5_5A5A_A5A5, 40'h3C_C3C3_3C3C};
    wait_rx(1, base + 2, 300);
    cmp_words(1, base);
    chk("gap1_period", 64'(rx_start[1][base + 1] - rx_start[1][base]), 64'd43);
    chk("gap1_high_run", 64'(rx_run[1][base + 1]), 64'd2);

    // Reset during data bit 20 of the first of two buffered frames.
    wait_idle0();
    d = 40'h12_3400_0000;
    if0.tx_data = d; if0.tx_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    if0.tx_data = 40'hFF_0000_FFFF;
    @(posedge clk); @(negedge clk);
    if0.tx_valid = 1'b0;
    repeat (21) @(negedge clk);
    chk("bit20_before_rst", 64'(to_mon0), 64'(d[20]));
    nbefore = rx_n[0];
    rst_n = 1'b0;
    #1;
    chk("async_rst_line", 64'(to_mon0), 64'd1);
    chk("async_rst_busy", 64'(busy0), 64'd0);
    chk("async_rst_ready", 64'(if0.tx_ready), 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    lows = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (!to_mon0) lows++;
    end
    chk("post_rst_lows", 64'(lows), 64'd0);
    chk("post_rst_busy", 64'(busy0), 64'd0);
    chk("post_rst_frames", 64'(rx_n[0]), 64'(nbefore));

    // Push coinciding with the pop in the last GAP cycle (count stays 1).
    base = rx_n[0];
    if0.tx_data = 40'h11_1111_1111; if0.tx_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    if0.tx_data = 40'h22_2222_2222;
    @(posedge clk); @(negedge clk);
    if0.tx_valid = 1'b0;
    repeat (45) @(negedge clk);
    if0.tx_data = 40'h33_3333_3333; if0.tx_valid = 1'b1;
    chk("ready_before_pushpop", 64'(if0.tx_ready), 64'd1);
    @(posedge clk); @(negedge clk);
    if0.tx_valid = 1'b0;
    chk("ready_after_pushpop", 64'(if0.tx_ready), 64'd1);
    exp_q = '{40'h11_1111_1111, 40'h22_2222_2222, 40'h33_3333_3333};
    wait_rx(0, base + 3, 300);
    cmp_words(0, base);
    chk("pushpop_period", 64'(rx_start[0][base + 2] - rx_start[0][base + 1]), 64'd46);

    // Random valid/data over 200 accepted frames.
    wait_idle0();
    base = rx_n[0]; s0 = sent_cnt[0]; acc = 0; g = 0;
    exp_q.delete();
    while (acc < 200 && g < 20000) begin
      v = 1'($urandom_range(0, 1));
      if0.tx_valid = v;
      if0.tx_data  = {8'($urandom), 32'($urandom)};
      r = v && if0.tx_ready;
      @(posedge clk);
      if (r) begin
        exp_q.push_back(if0.tx_data);
        acc++;
      end
      @(negedge clk);
      g++;
    end
    if0.tx_valid = 1'b0;
    chk("rand_accepts", 64'(acc), 64'd200);
    wait_rx(0, base + 200, 1000);
    cmp_words(0, base);
    chk("rand_sent_count", 64'(sent_cnt[0] - s0), 64'(acc));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
